mem_stage_s: RTL and testbench
==============================

# mem_stage_s

Memory stage of the 5-stage pipeline, directly downstream of the execute stage. Accepts one instruction per handshake from EX (ALU result, store data, destination register), performs loads and stores against an internal word-addressed data memory with a configurable access latency, and drives the MEM/WB outputs. It also provides the registered EX/MEM result used by the forwarding unit and back-pressures EX while a memory access is in flight.

## Interface
- DEPTH, 1024: data memory size in 32-bit words (power of two).
- MEM_LAT, 2: cycles spent in ACCESS per load/store (≥1).

- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- ex_valid  in  1  EX presents an instruction.
- ex_ready  out  1  stage can accept; transfer when ex_valid && ex_ready.
- ex_op  in  7  opcode: 0000011 load, 0100011 store, anything else is non-memory.
- ex_funct3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  instruction writes rd.
- ex_result  in  32  ALU result / effective address.
- ex_sData  in  32  forwarded store data.
- exmem_result  out  32  ex_result of last accepted instruction (forwarding source).
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  write-enable to register file.
- wb_data  out  32  ALU result or extended load data.
- mis_trap  out  1  misaligned access flag (qualified by wb_valid).

## Operation
- FSM: IDLE, ACCESS. ex_ready = (state == IDLE), combinational.
- IDLE + accept of non-memory op: stay IDLE; next cycle wb_valid=1, wb_data=ex_result, wb_rd/wb_reg_write from EX. Full throughput.
- IDLE + accept of load/store: capture op, funct3, rd, reg_write, address, store data; go ACCESS; latency counter loaded with MEM_LAT-1.
- ACCESS: counter decrements each cycle; at count 0, perform access and return to IDLE; wb_valid pulses the following cycle.
- Word index = ex_result[log2(DEPTH)+1:2]; higher bits ignored (address 4*DEPTH aliases 0).
- Byte lane = addr[1:0]; half lane = addr[1].
- Stores: SB/SH/SW update only addressed lanes; other funct3 values treated as SW. wb_reg_write forced 0 for stores regardless of ex_reg_write.
- Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; funct3 011/110/111 treated as LW.
- exmem_result updated on every accept, held otherwise.
- Memory contents not affected by reset.
- Reset mid-ACCESS: return to IDLE immediately, pending store not performed, no wb_valid for that instruction.

## Timing
- Reset values: state IDLE, ex_ready=1, wb_valid=0, wb_rd=0, wb_reg_write=0, wb_data=0, exmem_result=0, mis_trap=0.
- Non-memory: accept at cycle T → wb_valid at T+1.
- Load/store: accept at T → ex_ready=0 for T+1..T+MEM_LAT, access at edge ending T+MEM_LAT, wb_valid at T+MEM_LAT+1, ex_ready=1 at T+MEM_LAT+1 (a new accept is allowed that cycle).
- Load data visible on wb_data only in the wb_valid cycle; wb_* hold last values when wb_valid=0.
- Store-then-load to same address back-to-back returns the stored data.

## Configuration
- MISALIGN_TRAP_EN defined: half access with addr[0]=1 or word access with addr[1:0]≠0 performs no read/write, retires with the same latency, wb_reg_write=0, mis_trap=1 in the wb_valid cycle.
- Undefined: mis_trap tied 0; misaligned accesses ignore low bits (half uses addr[1] only, word ignores addr[1:0]).

## Test plan
- Reset, then ALU op ex_result=0x12345678, rd=5, reg_write=1 → next cycle wb_valid=1, wb_data=0x12345678, wb_rd=5; ex_ready stays 1; exmem_result=0x12345678.
- MEM_LAT=2: SW 0xDEADBEEF @0x10, then LW @0x10 → ex_ready low 2 cycles each; SW retires with wb_reg_write=0; LW retires at accept+3 with wb_data=0xDEADBEEF.
- SB 0x80 @0x13; LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080; LW @0x10 → 0x80ADBEEF; LH @0x12 → 0xFFFF80AD; LHU @0x12 → 0x000080AD.
- LW @0x11 with MISALIGN_TRAP_EN → mis_trap=1, wb_reg_write=0; without it → wb_data=0x80ADBEEF, mis_trap=0. SW 0x5 @(4*DEPTH) → LW @0 returns 0x5.
- SW 0x1 @0x20 (prior 0x0); assert reset during ACCESS → no wb_valid, all outputs at reset values; later LW @0x20 → 0x0.

Source files
------------

// File: rtl/mem_stage_s.sv
// rtl/mem_stage_s.sv - pipeline memory stage: word-addressed data memory with fixed access latency
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned half/word accesses instead of masking low bits)
module mem_stage_s #(
    parameter int DEPTH   = 1024,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [6:0]  ex_op,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_sData,
    output logic [31:0] exmem_result,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        mis_trap
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic            accept, do_access;
    logic            is_load_op, is_store_op, is_mem_op;

    logic            ld_q, rw_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic [31:0]     addr_q, sdata_q;

    logic            sz_byte, sz_half, trap;
    logic [AW-1:0]   widx;
    logic [3:0]      wmask;
    logic [31:0]     wdata, rword, ldata;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;

    logic [31:0]     mem [DEPTH];

    always_comb begin
        is_load_op  = (ex_op == 7'b0000011);
        is_store_op = (ex_op == 7'b0100011);
        is_mem_op   = is_load_op || is_store_op;
    end

    always_comb begin
        state_nx  = state;
        ex_ready  = (state == S_IDLE);
        accept    = ex_valid && ex_ready;
        do_access = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && is_mem_op) begin
                    state_nx = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt == '0) begin
                    do_access = 1'b1;
                    state_nx  = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept && is_mem_op) begin
                cnt <= CW'(MEM_LAT - 1);
            end else if (state == S_ACCESS && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Captured operands are only meaningful while in ACCESS, so they need no reset
    always_ff @(posedge clk) begin
        if (accept && is_mem_op) begin
            ld_q    <= is_load_op;
            f3_q    <= ex_funct3;
            rd_q    <= ex_rd;
            rw_q    <= ex_reg_write;
            addr_q  <= ex_result;
            sdata_q <= ex_sData;
        end
    end

    // Stores only know SB/SH; every other funct3 is a word store. Loads add BU/HU.
    always_comb begin
        sz_byte = (f3_q == 3'b000) || (ld_q && f3_q == 3'b100);
        sz_half = (f3_q == 3'b001) || (ld_q && f3_q == 3'b101);
`ifdef MISALIGN_TRAP_EN
        trap = sz_half ? addr_q[0] : (!sz_byte && addr_q[1:0] != 2'b00);
`else
        trap = 1'b0;
`endif
        widx = addr_q[AW+1:2];

        if (sz_byte) begin
            wmask = 4'b0001 << addr_q[1:0];
            wdata = {4{sdata_q[7:0]}};
        end else if (sz_half) begin
            wmask = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata = {2{sdata_q[15:0]}};
        end else begin
            wmask = 4'b1111;
            wdata = sdata_q;
        end

        rword = mem[widx];
        rbyte = rword[{addr_q[1:0], 3'b000} +: 8];
        rhalf = addr_q[1] ? rword[31:16] : rword[15:0];
        if (sz_byte) begin
            ldata = f3_q[2] ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
        end else if (sz_half) begin
            ldata = f3_q[2] ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
        end else begin
            ldata = rword;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_access && !ld_q && !trap) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exmem_result <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
            mis_trap     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (accept) begin
                exmem_result <= ex_result;
            end
            if (accept && !is_mem_op) begin
                wb_valid     <= 1'b1;
                wb_rd        <= ex_rd;
                wb_reg_write <= ex_reg_write;
                wb_data      <= ex_result;
                mis_trap     <= 1'b0;
            end else if (do_access) begin
                wb_valid     <= 1'b1;
                wb_rd        <= rd_q;
                wb_reg_write <= ld_q && rw_q && !trap;
                wb_data      <= (ld_q && !trap) ? ldata : addr_q;
                mis_trap     <= trap;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_s.sv
// tb/tb_mem_stage_s.sv - self-checking bench for mem_stage_s (vector table, corner sequences, random vs byte model)
module tb_mem_stage_s;
    localparam int DEPTH   = 1024;
    localparam int MEM_LAT = 2;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk, reset, ex_valid, ex_ready, ex_reg_write;
    logic [6:0]  ex_op;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd, wb_rd;
    logic [31:0] ex_result, ex_sData, exmem_result, wb_data;
    logic        wb_valid, wb_reg_write, mis_trap;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mb [4*DEPTH];

    mem_stage_s #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op(ex_op), .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_result(ex_result), .ex_sData(ex_sData), .exmem_result(exmem_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_data(wb_data), .mis_trap(mis_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] exp_data;
        logic        exp_rw;
        logic        exp_trap;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic rw, input logic [31:0] a, input logic [31:0] sd);
        ex_valid = 1'b1; ex_op = op; ex_funct3 = f3; ex_rd = rd;
        ex_reg_write = rw; ex_result = a; ex_sData = sd;
    endtask

    task automatic wait_wb(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_valid && n < 20);
    endtask

    // One instruction end to end: latency counted in cycles from accept to wb_valid
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                             input logic rw, input logic [31:0] a, input logic [31:0] sd,
                             output logic [31:0] d, output logic orw, output logic [4:0] ord,
                             output logic otrap, output int lat, output int stall,
                             output logic [31:0] em);
        @(negedge clk);
        drive(op, f3, rd, rw, a, sd);
        @(posedge clk);
        #1 ex_valid = 1'b0;
        lat = 0; stall = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) em = exmem_result;
            if (!ex_ready) stall++;
        end while (!wb_valid && lat < 20);
        d = wb_data; orw = wb_reg_write; ord = wb_rd; otrap = mis_trap;
    endtask

    // Reference: byte-addressed memory, natural alignment rules, modulo 4*DEPTH aliasing
    task automatic model_exec(input logic [6:0] op, input logic [2:0] f3, input logic rw,
                              input logic [31:0] a, input logic [31:0] sd,
                              output logic [31:0] ed, output logic erw, output logic etrap,
                              output int elat, output int estall);
        int n, base, al;
        logic [31:0] v;
        if (op != OP_LD && op != OP_ST) begin
            ed = a; erw = rw; etrap = 1'b0; elat = 1; estall = 0;
            return;
        end
        if (op == OP_ST) n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else             n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        base  = int'(a % (4 * DEPTH));
        al    = base - (base % n);
        etrap = TRAP_EN && (base % n != 0);
        elat  = MEM_LAT + 1;
        estall = MEM_LAT;
        ed = a; erw = 1'b0;
        if (!etrap) begin
            if (op == OP_ST) begin
                for (int i = 0; i < n; i++) mb[al + i] = sd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(mb[al + i]) << (8 * i));
                if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
                ed = v; erw = rw;
            end
        end
    endtask

    vec_t tbl[13];

    initial begin
        logic [31:0] d, em, ed, vals[3];
        logic        orw, otrap, erw, etrap;
        logic [4:0]  ord;
        int          lat, stall, elat, estall, n, hits;

        for (int i = 0; i < 4 * DEPTH; i++) mb[i] = 8'h00;
        reset = 1'b1; ex_valid = 1'b0; ex_op = OP_ALU; ex_funct3 = 3'd0; ex_rd = 5'd0;
        ex_reg_write = 1'b0; ex_result = 32'd0; ex_sData = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset ex_ready", 32'(ex_ready), 32'd1);
        chk("reset wb_valid", 32'(wb_valid), 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset wb_rd", 32'(wb_rd), 32'd0);
        chk("reset wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("reset exmem_result", exmem_result, 32'd0);
        chk("reset mis_trap", 32'(mis_trap), 32'd0);
        reset = 1'b0;

        tbl[0]  = '{OP_ALU, 3'd0, 5'd5,  1'b1, 32'h1234_5678, 32'h0,         32'h1234_5678, 1'b1, 1'b0};
        tbl[1]  = '{OP_ST,  3'd2, 5'd0,  1'b1, 32'h10,        32'hDEAD_BEEF, 32'h10,        1'b0, 1'b0};
        tbl[2]  = '{OP_LD,  3'd2, 5'd6,  1'b1, 32'h10,        32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0};
        tbl[3]  = '{OP_ST,  3'd0, 5'd0,  1'b0, 32'h13,        32'h0000_0080, 32'h13,        1'b0, 1'b0};
        tbl[4]  = '{OP_LD,  3'd0, 5'd7,  1'b1, 32'h13,        32'h0,         32'hFFFF_FF80, 1'b1, 1'b0};
        tbl[5]  = '{OP_LD,  3'd4, 5'd8,  1'b1, 32'h13,        32'h0,         32'h0000_0080, 1'b1, 1'b0};
        tbl[6]  = '{OP_LD,  3'd2, 5'd9,  1'b1, 32'h10,        32'h0,         32'h80AD_BEEF, 1'b1, 1'b0};
        tbl[7]  = '{OP_LD,  3'd1, 5'd10, 1'b1, 32'h12,        32'h0,         32'hFFFF_80AD, 1'b1, 1'b0};
        tbl[8]  = '{OP_LD,  3'd5, 5'd11, 1'b1, 32'h12,        32'h0,         32'h0000_80AD, 1'b1, 1'b0};
`ifdef MISALIGN_TRAP_EN
        tbl[9]  = '{OP_LD,  3'd2, 5'd12, 1'b1, 32'h11,        32'h0,         32'h11,        1'b0, 1'b1};
`else
        tbl[9]  = '{OP_LD,  3'd2, 5'd12, 1'b1, 32'h11,        32'h0,         32'h80AD_BEEF, 1'b1, 1'b0};
`endif
        tbl[10] = '{OP_ST,  3'd2, 5'd0,  1'b0, 32'(4 * DEPTH), 32'h5,        32'(4 * DEPTH), 1'b0, 1'b0};
        tbl[11] = '{OP_LD,  3'd2, 5'd13, 1'b1, 32'h0,         32'h0,         32'h5,         1'b1, 1'b0};
        tbl[12] = '{OP_ST,  3'd2, 5'd0,  1'b0, 32'h20,        32'h0,         32'h20,        1'b0, 1'b0};

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].f3, tbl[i].rd, tbl[i].rw, tbl[i].addr, tbl[i].sd,
                      d, orw, ord, otrap, lat, stall, em);
            chk($sformatf("vec%0d wb_data", i), d, tbl[i].exp_data);
            chk($sformatf("vec%0d wb_reg_write", i), 32'(orw), 32'(tbl[i].exp_rw));
            chk($sformatf("vec%0d wb_rd", i), 32'(ord), 32'(tbl[i].rd));
            chk($sformatf("vec%0d mis_trap", i), 32'(otrap), 32'(tbl[i].exp_trap));
            chk($sformatf("vec%0d latency", i), 32'(lat),
                (tbl[i].op == OP_LD || tbl[i].op == OP_ST) ? 32'(MEM_LAT + 1) : 32'd1);
            chk($sformatf("vec%0d stall cycles", i), 32'(stall),
                (tbl[i].op == OP_LD || tbl[i].op == OP_ST) ? 32'(MEM_LAT) : 32'd0);
            chk($sformatf("vec%0d exmem_result", i), em, tbl[i].addr);
        end

        // wb outputs hold once the retire pulse is over
        run_instr(OP_LD, 3'd2, 5'd14, 1'b1, 32'h10, 32'h0, d, orw, ord, otrap, lat, stall, em);
        @(negedge clk);
        chk("hold wb_valid", 32'(wb_valid), 32'd0);
        chk("hold wb_data", wb_data, 32'h80AD_BEEF);
        chk("hold wb_rd", 32'(wb_rd), 32'd14);

        // Back-to-back ALU ops retire one per cycle
        vals[0] = 32'hA000_0001; vals[1] = 32'hB000_0002; vals[2] = 32'hC000_0003;
        @(negedge clk);
        drive(OP_ALU, 3'd0, 5'd1, 1'b1, vals[0], 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d wb_valid", k), 32'(wb_valid), 32'd1);
            chk($sformatf("b2b%0d wb_data", k), wb_data, vals[k]);
            chk($sformatf("b2b%0d ex_ready", k), 32'(ex_ready), 32'd1);
            if (k < 2) drive(OP_ALU, 3'd0, 5'(k + 2), 1'b1, vals[k+1], 32'h0);
            else ex_valid = 1'b0;
        end

        // Store then load presented back-to-back; load accepted in the store's retire cycle
        @(negedge clk);
        drive(OP_ST, 3'd2, 5'd0, 1'b0, 32'h28, 32'h600D_F00D);
        @(posedge clk);
        #1 drive(OP_LD, 3'd2, 5'd15, 1'b1, 32'h28, 32'h0);
        for (int k = 0; k < MEM_LAT; k++) begin
            @(negedge clk);
            chk($sformatf("st-ld stall%0d ex_ready", k), 32'(ex_ready), 32'd0);
        end
        @(negedge clk);
        chk("st-ld store retire", 32'(wb_valid), 32'd1);
        chk("st-ld ready on retire", 32'(ex_ready), 32'd1);
        @(posedge clk);
        #1 ex_valid = 1'b0;
        wait_wb(n);
        chk("st-ld load latency", 32'(n), 32'(MEM_LAT + 1));
        chk("st-ld load data", wb_data, 32'h600D_F00D);

        // Reset in the last ACCESS cycle of a store: no retire, store dropped
        @(negedge clk);
        drive(OP_ST, 3'd2, 5'd3, 1'b1, 32'h20, 32'h1);
        @(posedge clk);
        #1 ex_valid = 1'b0;
        repeat (MEM_LAT) @(negedge clk);
        chk("rst-mid ex_ready low", 32'(ex_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst-mid wb_valid", 32'(wb_valid), 32'd0);
        chk("rst-mid ex_ready", 32'(ex_ready), 32'd1);
        chk("rst-mid wb_data", wb_data, 32'd0);
        chk("rst-mid wb_rd", 32'(wb_rd), 32'd0);
        chk("rst-mid exmem_result", exmem_result, 32'd0);
        reset = 1'b0;
        hits = 0;
        repeat (5) begin
            @(negedge clk);
            if (wb_valid) hits++;
        end
        chk("rst-mid stray wb_valid", 32'(hits), 32'd0);
        run_instr(OP_LD, 3'd2, 5'd4, 1'b1, 32'h20, 32'h0, d, orw, ord, otrap, lat, stall, em);
        chk("rst-mid store dropped", d, 32'h0);

        // Random phase: seed window 0..63, then mixed ops with aliasing
        for (int w = 0; w < 16; w++) begin
            logic [31:0] sv;
            sv = $urandom;
            model_exec(OP_ST, 3'd2, 1'b0, 32'(4 * w), sv, ed, erw, etrap, elat, estall);
            run_instr(OP_ST, 3'd2, 5'd0, 1'b0, 32'(4 * w), sv, d, orw, ord, otrap, lat, stall, em);
            chk($sformatf("seed%0d latency", w), 32'(lat), 32'(elat));
        end
        for (int it = 0; it < 300; it++) begin
            logic [6:0]  op;
            logic [2:0]  f3;
            logic [4:0]  rd;
            logic        rw;
            logic [31:0] a, sd;
            int kind;
            kind = $urandom_range(0, 2);
            op = (kind == 0) ? OP_ALU : (kind == 1) ? OP_LD : OP_ST;
            f3 = 3'($urandom_range(0, 7));
            rd = 5'($urandom);
            rw = 1'($urandom);
            sd = $urandom;
            a  = (kind == 0) ? $urandom
                             : 32'($urandom_range(0, 63) + $urandom_range(0, 2) * 4 * DEPTH);
            model_exec(op, f3, rw, a, sd, ed, erw, etrap, elat, estall);
            run_instr(op, f3, rd, rw, a, sd, d, orw, ord, otrap, lat, stall, em);
            chk($sformatf("rnd%0d op=%b f3=%0d a=%h wb_data", it, op, f3, a), d, ed);
            chk($sformatf("rnd%0d wb_reg_write", it), 32'(orw), 32'(erw));
            chk($sformatf("rnd%0d wb_rd", it), 32'(ord), 32'(rd));
            chk($sformatf("rnd%0d mis_trap", it), 32'(otrap), 32'(etrap));
            chk($sformatf("rnd%0d latency", it), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d stall", it), 32'(stall), 32'(estall));
            chk($sformatf("rnd%0d exmem_result", it), em, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
